fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Parameterised instruction-fetch stage; successor to the single-register fetch block.
- Holds the program counter and issues requests to instruction memory through a request/grant/response handshake.
- Buffers fetched {pc, instruction} pairs in a small queue feeding decode under valid/ready backpressure.
- Supports redirect (jump/branch) with flush of queued and in-flight fetches.

Parameters:
PC_WIDTH, 16, width of pc, pc_target, imem_addr, out_pc
INSTR_WIDTH, 32, instruction word width
RESET_PC, 0, pc value loaded on reset
PC_STEP, 4, sequential pc increment
FQ_DEPTH, 2, fetch-queue entries (power of two, >= 2)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous active-high reset
next_pc_select  input  1  redirect request; 1 = load pc_target
pc_target  input  PC_WIDTH  redirect address
pc  output  PC_WIDTH  next address to be requested
imem_req  output  1  fetch request valid
imem_addr  output  PC_WIDTH  fetch address (equals pc)
imem_gnt  input  1  memory accepts request this cycle
imem_rsp_valid  input  1  response data valid
imem_rsp_data  input  INSTR_WIDTH  fetched instruction
out_valid  output  1  queue head valid
out_pc  output  PC_WIDTH  pc of head instruction
out_instr  output  INSTR_WIDTH  head instruction
out_ready  input  1  decode accepts head

Behaviour:
- Reset (rst=1 at an edge): pc=RESET_PC, queue empty, state=REQ. While rst is high: out_valid=0, imem_req=0. Memory shares rst and drops outstanding requests, so no response arrives after reset.
- FSM states:
  - REQ: imem_req=1 when rst=0 and (queue count + 0 outstanding) < FQ_DEPTH. On imem_req && imem_gnt, go to WAIT.
  - WAIT: imem_req=0. On imem_rsp_valid, push {pc, imem_rsp_data}, pc <= pc + PC_STEP, go to REQ.
  - DRAIN: imem_req=0. Discard the next imem_rsp_valid, then go to REQ.
- One outstanding request at most; throughput is one instruction per 2 cycles with a zero-wait memory (grant in the request cycle, response the next cycle).
- PC arithmetic is modulo 2^PC_WIDTH (wraps); pc_target is used unaligned, as given.
- Output: out_valid = queue non-empty; out_pc and out_instr come from the head. Pop on out_valid && out_ready. Push and pop may occur in the same cycle.
- A request is issued only when a free slot is guaranteed, so a push never overflows.
- Redirect (next_pc_select=1, rst=0) has priority over push, pop and request in that cycle:
  - pc <= pc_target; queue flushed (out_valid=0 next cycle); imem_req forced 0 that cycle.
  - In REQ: next state REQ; the following request uses pc_target.
  - In WAIT without rsp_valid: go to DRAIN.
  - In WAIT with rsp_valid that cycle: the response is dropped; go to REQ.
  - In DRAIN: stay in DRAIN until the stale response arrives; if it arrives that cycle, go to REQ.
- rst has priority over redirect. rst mid-operation (any state) returns to reset values at the next edge.

Decomposition:
- Package fetch_pkg: FSM state enum (REQ, WAIT, DRAIN); queue-entry struct {pc, instr}; default parameter constants.
- Sub-module fetch_queue: synchronous FIFO (FQ_DEPTH entries) with push, pop, flush, count, empty; flush has priority over push and pop.

Test Plan:
1. rst=1 for 2 cycles, then 0 -> during rst pc=0000, out_valid=0, imem_req=0; first cycle after rst: imem_req=1, imem_addr=0000.
2. Sequential fetch: imem_gnt=1, response one cycle after grant with data 00000013, 00100093, 00200113; out_ready=1 -> out_pc 0000, 0004, 0008 with matching instr; pc=000C after the third response.
3. Backpressure: out_ready=0 -> two entries queued (0000, 0004), imem_req stays 0, pc holds 0008. Raise out_ready -> pops in order, requests resume at 0008.
4. Redirect in WAIT: pc_target=1010, next_pc_select=1 pulse -> queue empties, the stale response (data DEADBEEF) never appears at the output, next imem_addr=1010, first out_pc=1010.
5. Redirect coincident with imem_rsp_valid -> that response is dropped, FSM goes to REQ, imem_req=1 with imem_addr=1010 on the following cycle.
6. Wrap and reset mid-op: redirect to FFFC, fetch -> out_pc FFFC then 0000. Assert rst while in WAIT -> next cycle pc=0000, out_valid=0, FSM in REQ.

Source files
------------

// File: rtl/fetch_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fetch_pkg                                                     |
// | Purpose  : Shared types and default constants for the fetch stage.       |
// |            - fetch_state_t : sequencer states (request / wait / drain)   |
// |            - fq_entry_t    : layout of one queue word at default widths  |
// |            - DEF_*         : default parameter values                    |
// | Revision : 1.0  initial parameterised release                            |
// +--------------------------------------------------------------------------+
package fetch_pkg;

   localparam int DEF_PC_WIDTH    = 16;
   localparam int DEF_INSTR_WIDTH = 32;
   localparam int DEF_RESET_PC    = 0;
   localparam int DEF_PC_STEP     = 4;
   localparam int DEF_FQ_DEPTH    = 2;

   typedef enum logic [1:0] {
      S_REQ   = 2'd0,   // may issue a request
      S_WAIT  = 2'd1,   // one request outstanding, response will be queued
      S_DRAIN = 2'd2    // one stale request outstanding, response is discarded
   } fetch_state_t;

   // Queue words are stored as {pc, instr}; this struct names the fields
   // for the default-width configuration.
   typedef struct packed {
      logic [DEF_PC_WIDTH-1:0]    pc;
      logic [DEF_INSTR_WIDTH-1:0] instr;
   } fq_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fetch_queue                                                   |
// | Purpose  : Synchronous FIFO holding fetched {pc, instr} words.           |
// |            Flush has priority over push and pop.                         |
// | Ports    : clk, rst        clock / synchronous active-high reset         |
// |            flush           empty the queue at the next edge              |
// |            push, push_data write a word (ignored when full, no pop)      |
// |            pop             remove the head word (ignored when empty)     |
// |            head_data       current head word                             |
// |            count, empty    occupancy                                     |
// | Revision : 1.0  initial parameterised release                            |
// +--------------------------------------------------------------------------+
module fetch_queue #(
   parameter  int DEPTH = 2,
   parameter  int WIDTH = 48,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic [CW-1:0]    count,
   output logic             empty
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             full;
   logic             do_push;
   logic             do_pop;

   assign empty     = (count == '0);
   assign full      = (count == CW'(DEPTH));
   assign do_pop    = pop && !empty;
   // A pop in the same cycle frees the slot the push needs.
   assign do_push   = push && (!full || do_pop);
   assign head_data = mem[rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset; only the pointers define validity.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fetch_unit                                                    |
// | Purpose  : Instruction-fetch stage. Holds the pc, fetches through a      |
// |            req/gnt/rsp handshake with at most one request outstanding,   |
// |            queues {pc, instr} for decode, and handles redirects by       |
// |            flushing the queue and discarding any in-flight response.     |
// | Ports    : clk, rst                     clock / sync active-high reset   |
// |            next_pc_select, pc_target    redirect request and address     |
// |            pc                           next address to be requested     |
// |            imem_req/addr/gnt            request channel                  |
// |            imem_rsp_valid/data          response channel                 |
// |            out_valid/pc/instr/ready     decode interface                 |
// | Revision : 1.0  initial parameterised release                            |
// +--------------------------------------------------------------------------+
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int                  PC_WIDTH    = DEF_PC_WIDTH,
   parameter int                  INSTR_WIDTH = DEF_INSTR_WIDTH,
   parameter logic [PC_WIDTH-1:0] RESET_PC    = PC_WIDTH'(DEF_RESET_PC),
   parameter int                  PC_STEP     = DEF_PC_STEP,
   parameter int                  FQ_DEPTH    = DEF_FQ_DEPTH
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   next_pc_select,
   input  logic [PC_WIDTH-1:0]    pc_target,
   output logic [PC_WIDTH-1:0]    pc,
   output logic                   imem_req,
   output logic [PC_WIDTH-1:0]    imem_addr,
   input  logic                   imem_gnt,
   input  logic                   imem_rsp_valid,
   input  logic [INSTR_WIDTH-1:0] imem_rsp_data,
   output logic                   out_valid,
   output logic [PC_WIDTH-1:0]    out_pc,
   output logic [INSTR_WIDTH-1:0] out_instr,
   input  logic                   out_ready
);

   localparam int CW = $clog2(FQ_DEPTH) + 1;
   localparam int EW = PC_WIDTH + INSTR_WIDTH;

   fetch_state_t  state;
   logic [CW-1:0] q_count;
   logic          q_empty;
   logic [EW-1:0] q_head;
   logic          q_push;
   logic          q_pop;

   assign imem_addr = pc;

   // Only one request can be outstanding, so a free slot now is a free
   // slot when the response lands. Redirect suppresses the request so the
   // old pc is never granted in the cycle it is being replaced.
   assign imem_req  = !rst && !next_pc_select && (state == S_REQ)
                      && (q_count < CW'(FQ_DEPTH));

   assign out_valid = !rst && !q_empty;
   assign out_pc    = q_head[EW-1 -: PC_WIDTH];
   assign out_instr = q_head[INSTR_WIDTH-1:0];

   assign q_push = !rst && !next_pc_select && (state == S_WAIT) && imem_rsp_valid;
   assign q_pop  = out_valid && out_ready;

   fetch_queue #(
      .DEPTH (FQ_DEPTH),
      .WIDTH (EW)
   ) u_queue (
      .clk       (clk),
      .rst       (rst),
      .flush     (next_pc_select),
      .push      (q_push),
      .push_data ({pc, imem_rsp_data}),
      .pop       (q_pop),
      .head_data (q_head),
      .count     (q_count),
      .empty     (q_empty)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         pc    <= RESET_PC;
         state <= S_REQ;
      end else if (next_pc_select) begin
         pc <= pc_target;
         // A request still in flight must be drained; if its response
         // arrives this very cycle it is dropped here instead.
         case (state)
            S_REQ:   state <= S_REQ;
            S_WAIT:  state <= imem_rsp_valid ? S_REQ : S_DRAIN;
            S_DRAIN: state <= imem_rsp_valid ? S_REQ : S_DRAIN;
            default: state <= S_REQ;
         endcase
      end else begin
         case (state)
            S_REQ: begin
               if (imem_req && imem_gnt) state <= S_WAIT;
            end
            S_WAIT: begin
               if (imem_rsp_valid) begin
                  pc    <= pc + PC_WIDTH'(PC_STEP);
                  state <= S_REQ;
               end
            end
            S_DRAIN: begin
               if (imem_rsp_valid) state <= S_REQ;
            end
            default: state <= S_REQ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_fetch_unit                                                 |
// | Purpose  : Directed self-checking bench for fetch_unit with a small      |
// |            zero-wait instruction memory that can hold its response or    |
// |            return a poisoned stale word.                                 |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_fetch_unit;

   logic        clk;
   logic        rst;
   logic        next_pc_select;
   logic [15:0] pc_target;
   logic [15:0] pc;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        out_valid;
   logic [15:0] out_pc;
   logic [31:0] out_instr;
   logic        out_ready;

   int total;
   int bad;

   // memory model controls
   logic        pend;
   logic [15:0] paddr;
   logic        hold_rsp;
   logic        stale;

   fetch_unit #(
      .PC_WIDTH    (16),
      .INSTR_WIDTH (32),
      .RESET_PC    (16'h0000),
      .PC_STEP     (4),
      .FQ_DEPTH    (2)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .next_pc_select (next_pc_select),
      .pc_target      (pc_target),
      .pc             (pc),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_gnt       (imem_gnt),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .out_valid      (out_valid),
      .out_pc         (out_pc),
      .out_instr      (out_instr),
      .out_ready      (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [15:0] a);
      case (a)
         16'h0000: return 32'h00000013;
         16'h0004: return 32'h00100093;
         16'h0008: return 32'h00200113;
         16'h000C: return 32'h00300193;
         16'h1010: return 32'h00400213;
         16'h1014: return 32'h00500293;
         16'hFFFC: return 32'h00600313;
         default:  return {16'hA5A5, a};
      endcase
   endfunction

   // Response one cycle after grant unless held.
   always @(posedge clk) begin
      if (rst) pend <= 1'b0;
      else if (imem_req && imem_gnt) begin
         pend  <= 1'b1;
         paddr <= imem_addr;
      end else if (imem_rsp_valid) pend <= 1'b0;
   end
   assign imem_rsp_valid = pend && !hold_rsp;
   assign imem_rsp_data  = stale ? 32'hDEADBEEF : mem_word(paddr);

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; next_pc_select = 1'b0; hold_rsp = 1'b0; stale = 1'b0;
      tick(); tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; next_pc_select = 1'b0; pc_target = 16'h0; imem_gnt = 1'b0;
      out_ready = 1'b0; hold_rsp = 1'b0; stale = 1'b0;
      for (int c = 0; c < 2; c++) begin
         tick();
         total++;
         if (pc !== 16'h0000 || out_valid !== 1'b0 || imem_req !== 1'b0) begin
            bad++;
            $display("FAIL reset_hold%0d pc=%h out_valid=%b imem_req=%b required 0000/0/0", c, pc, out_valid, imem_req);
         end
      end
      rst = 1'b0;
      #1;
      total++;
      if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
         bad++;
         $display("FAIL reset_first_req imem_req=%b addr=%h required 1/0000", imem_req, imem_addr);
      end
   endtask

   task automatic test_sequential();
      logic [15:0] ep [3];
      logic [31:0] ei [3];
      int seen;
      ep[0] = 16'h0000; ep[1] = 16'h0004; ep[2] = 16'h0008;
      ei[0] = 32'h00000013; ei[1] = 32'h00100093; ei[2] = 32'h00200113;
      imem_gnt = 1'b1; out_ready = 1'b1; seen = 0;
      for (int c = 0; c < 30 && seen < 3; c++) begin
         if (out_valid) begin
            total++;
            if (out_pc !== ep[seen] || out_instr !== ei[seen]) begin
               bad++;
               $display("FAIL seq_out%0d pc=%h instr=%h required %h/%h", seen, out_pc, out_instr, ep[seen], ei[seen]);
            end
            seen++;
            if (seen == 3) begin
               total++;
               if (pc !== 16'h000C) begin
                  bad++;
                  $display("FAIL seq_pc pc=%h required 000C", pc);
               end
            end
         end
         tick();
      end
      total++;
      if (seen != 3) begin
         bad++;
         $display("FAIL seq_timeout seen=%0d required 3", seen);
      end
   endtask

   task automatic test_backpressure();
      logic [15:0] ep [3];
      int seen;
      bit  req_checked;
      do_reset();
      ep[0] = 16'h0000; ep[1] = 16'h0004; ep[2] = 16'h0008;
      imem_gnt = 1'b1; out_ready = 1'b0;
      for (int c = 0; c < 10; c++) begin
         if (c >= 6) begin
            total++;
            if (imem_req !== 1'b0) begin
               bad++;
               $display("FAIL bp_req_stall cycle %0d imem_req=%b required 0", c, imem_req);
            end
         end
         tick();
      end
      total++;
      if (out_valid !== 1'b1 || out_pc !== 16'h0000 || out_instr !== 32'h00000013 || pc !== 16'h0008) begin
         bad++;
         $display("FAIL bp_hold out_valid=%b out_pc=%h instr=%h pc=%h required 1/0000/00000013/0008", out_valid, out_pc, out_instr, pc);
      end
      out_ready = 1'b1; seen = 0; req_checked = 0;
      for (int c = 0; c < 30 && seen < 3; c++) begin
         if (imem_req && !req_checked) begin
            req_checked = 1;
            total++;
            if (imem_addr !== 16'h0008) begin
               bad++;
               $display("FAIL bp_resume_addr addr=%h required 0008", imem_addr);
            end
         end
         if (out_valid) begin
            total++;
            if (out_pc !== ep[seen]) begin
               bad++;
               $display("FAIL bp_pop%0d pc=%h required %h", seen, out_pc, ep[seen]);
            end
            seen++;
         end
         tick();
      end
      total++;
      if (seen != 3 || !req_checked) begin
         bad++;
         $display("FAIL bp_timeout seen=%0d resumed=%0d required 3/1", seen, req_checked);
      end
   endtask

   task automatic test_redirect_wait();
      int n;
      bit got;
      do_reset();
      imem_gnt = 1'b1; out_ready = 1'b0;
      n = 0;
      while (!out_valid && n < 20) begin tick(); n++; end
      hold_rsp = 1'b1;                 // next request stays outstanding
      tick();                          // now in WAIT with response held
      stale = 1'b1; pc_target = 16'h1010; next_pc_select = 1'b1;
      #1;
      total++;
      if (imem_req !== 1'b0 || out_valid !== 1'b1) begin
         bad++;
         $display("FAIL rw_setup imem_req=%b out_valid=%b required 0/1", imem_req, out_valid);
      end
      tick();
      next_pc_select = 1'b0;
      #1;
      total++;
      if (out_valid !== 1'b0 || pc !== 16'h1010 || imem_req !== 1'b0) begin
         bad++;
         $display("FAIL rw_flush out_valid=%b pc=%h imem_req=%b required 0/1010/0", out_valid, pc, imem_req);
      end
      hold_rsp = 1'b0;                 // stale DEADBEEF arrives now
      tick();
      stale = 1'b0;
      total++;
      if (imem_req !== 1'b1 || imem_addr !== 16'h1010 || out_valid !== 1'b0) begin
         bad++;
         $display("FAIL rw_req imem_req=%b addr=%h out_valid=%b required 1/1010/0", imem_req, imem_addr, out_valid);
      end
      out_ready = 1'b1; got = 0;
      for (int c = 0; c < 20 && !got; c++) begin
         if (out_valid) begin
            got = 1;
            total++;
            if (out_pc !== 16'h1010 || out_instr !== 32'h00400213) begin
               bad++;
               $display("FAIL rw_first pc=%h instr=%h required 1010/00400213", out_pc, out_instr);
            end
         end
         tick();
      end
      total++;
      if (!got) begin
         bad++;
         $display("FAIL rw_timeout got=0 required 1");
      end
   endtask

   task automatic test_redirect_rsp();
      bit got;
      do_reset();
      imem_gnt = 1'b1; out_ready = 1'b1;
      tick();                          // response cycle for pc 0000
      pc_target = 16'h1010; next_pc_select = 1'b1;
      tick();
      next_pc_select = 1'b0;
      #1;
      total++;
      if (out_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h1010) begin
         bad++;
         $display("FAIL rr_req out_valid=%b imem_req=%b addr=%h required 0/1/1010", out_valid, imem_req, imem_addr);
      end
      got = 0;
      for (int c = 0; c < 20 && !got; c++) begin
         if (out_valid) begin
            got = 1;
            total++;
            if (out_pc !== 16'h1010 || out_instr !== 32'h00400213) begin
               bad++;
               $display("FAIL rr_first pc=%h instr=%h required 1010/00400213", out_pc, out_instr);
            end
         end
         tick();
      end
      total++;
      if (!got) begin
         bad++;
         $display("FAIL rr_timeout got=0 required 1");
      end
   endtask

   task automatic test_wrap_reset();
      logic [15:0] ep [2];
      logic [31:0] ei [2];
      int seen;
      do_reset();
      ep[0] = 16'hFFFC; ep[1] = 16'h0000;
      ei[0] = 32'h00600313; ei[1] = 32'h00000013;
      imem_gnt = 1'b1; out_ready = 1'b1;
      pc_target = 16'hFFFC; next_pc_select = 1'b1;
      #1;
      total++;
      if (imem_req !== 1'b0) begin
         bad++;
         $display("FAIL wr_req_forced imem_req=%b required 0", imem_req);
      end
      tick();
      next_pc_select = 1'b0;
      seen = 0;
      for (int c = 0; c < 30 && seen < 2; c++) begin
         if (out_valid) begin
            total++;
            if (out_pc !== ep[seen] || out_instr !== ei[seen]) begin
               bad++;
               $display("FAIL wr_out%0d pc=%h instr=%h required %h/%h", seen, out_pc, out_instr, ep[seen], ei[seen]);
            end
            seen++;
            if (seen == 2) hold_rsp = 1'b1;   // keep the next fetch in WAIT
         end
         tick();
      end
      total++;
      if (seen != 2) begin
         bad++;
         $display("FAIL wr_timeout seen=%0d required 2", seen);
      end
      rst = 1'b1;
      #1;
      total++;
      if (imem_req !== 1'b0 || out_valid !== 1'b0 || pc !== 16'h0004) begin
         bad++;
         $display("FAIL wr_in_rst imem_req=%b out_valid=%b pc=%h required 0/0/0004", imem_req, out_valid, pc);
      end
      tick();
      rst = 1'b0; hold_rsp = 1'b0;
      #1;
      total++;
      if (pc !== 16'h0000 || out_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
         bad++;
         $display("FAIL wr_after_rst pc=%h out_valid=%b imem_req=%b addr=%h required 0000/0/1/0000", pc, out_valid, imem_req, imem_addr);
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_sequential();
      test_backpressure();
      test_redirect_wait();
      test_redirect_rsp();
      test_wrap_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
